// File: rtl/dma_read_scheduler_if.sv
// Read-master command/data bus and the buffered output stream of dma_read_scheduler.
interface dma_read_scheduler_if;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic [3:0]  rd_len;
  logic [3:0]  rd_id;
  logic        rd_stall;
  logic [31:0] rd_data;
  logic        rd_rvalid;
  logic        rd_rlast;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output rd_req, rd_addr, rd_len, rd_id,
    input  rd_stall, rd_data, rd_rvalid, rd_rlast,
    output out_data, out_valid,
    input  out_ready
  );

  modport slave (
    input  rd_req, rd_addr, rd_len, rd_id,
    output rd_stall, rd_data, rd_rvalid, rd_rlast,
    input  out_data, out_valid,
    output out_ready
  );
endinterface

// File: rtl/dma_read_scheduler.sv
// Splits one DMA read descriptor into 4KB-safe INCR bursts and buffers the returned beats.
// Optional DMA_RD_SCHED_PERF_EN adds busy/wait performance counters.
module dma_read_scheduler #(
  parameter int         BURST_MAX  = 16,
  parameter int         FIFO_DEPTH = 32,
  parameter int         LEN_W      = 16,
  parameter logic [3:0] RD_ID      = 4'd0
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [LEN_W-1:0] len_words,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  dma_read_scheduler_if.master bus
`ifdef DMA_RD_SCHED_PERF_EN
  ,
  output logic [31:0]      perf_busy_cycles,
  output logic [31:0]      perf_wait_cycles
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DATA, DRAIN} state_t;

  state_t             state_q, state_d;
  logic [31:0]        cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]   remaining_q, remaining_d;
  logic [4:0]         beats_q, beats_d;
  logic               rd_req_q, rd_req_d;
  logic [31:0]        rd_addr_q, rd_addr_d;
  logic [3:0]         rd_len_q, rd_len_d;
  logic               aborted_q, aborted_d;
  logic               done_q, done_d;

  logic [31:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, free_c;
  logic               push, pop, fifo_empty;

  logic [10:0]        to_bound;
  logic [4:0]         beats_c;
  logic               space_ok, last_beat, accept;
  logic [LEN_W-1:0]   rem_after;
  logic               unused_bits;

  assign accept     = (state_q == IDLE) && start;
  assign fifo_empty = (count_q == '0);
  assign free_c     = CNT_W'(FIFO_DEPTH) - count_q;
  assign push       = (state_q == DATA) && bus.rd_rvalid;
  assign pop        = !fifo_empty && bus.out_ready;
  assign last_beat  = push && bus.rd_rlast;
  assign rem_after  = remaining_q - LEN_W'(beats_q);
  assign unused_bits = &{1'b0, src_addr[1:0], bus.rd_stall};

  // Words left before the next 4KB page; always 1..1024.
  assign to_bound = 11'((13'd4096 - {1'b0, cur_addr_q[11:0]}) >> 2);

  always_comb begin
    beats_c = 5'(BURST_MAX);
    if (remaining_q < LEN_W'(BURST_MAX)) beats_c = remaining_q[4:0];
    if (to_bound < 11'(beats_c))          beats_c = to_bound[4:0];
  end

  // The master never backpressures read data, so a burst only issues once its beats fit.
  assign space_ok = (free_c >= CNT_W'(beats_c));

  always_ff @(posedge ACLK or posedge ARESETn) begin
    if (ARESETn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = (len_words == '0) ? DRAIN : ISSUE;
      ISSUE:   if (abort) state_d = DRAIN;
               else if (space_ok) state_d = DATA;
      DATA:    if (last_beat) state_d = ((rem_after == '0) || abort) ? DRAIN : ISSUE;
      DRAIN:   if (fifo_empty) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    beats_d     = beats_q;
    rd_req_d    = 1'b0;
    rd_addr_d   = rd_addr_q;
    rd_len_d    = rd_len_q;
    aborted_d   = aborted_q;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE: if (start) begin
        cur_addr_d  = {src_addr[31:2], 2'b00};
        remaining_d = len_words;
        aborted_d   = 1'b0;
      end
      ISSUE: if (abort) begin
        aborted_d = 1'b1;
      end else if (space_ok) begin
        rd_req_d  = 1'b1;
        rd_addr_d = cur_addr_q;
        rd_len_d  = 4'(beats_c - 5'd1);
        beats_d   = beats_c;
      end
      DATA: if (last_beat) begin
        remaining_d = rem_after;
        cur_addr_d  = cur_addr_q + {25'd0, beats_q, 2'b00};
        if (abort && (rem_after != '0)) aborted_d = 1'b1;
      end
      DRAIN: if (fifo_empty) done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESETn) begin
    if (ARESETn) begin
      cur_addr_q  <= '0;
      remaining_q <= '0;
      beats_q     <= '0;
      rd_req_q    <= 1'b0;
      rd_addr_q   <= '0;
      rd_len_q    <= '0;
      aborted_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      beats_q     <= beats_d;
      rd_req_q    <= rd_req_d;
      rd_addr_q   <= rd_addr_d;
      rd_len_q    <= rd_len_d;
      aborted_q   <= aborted_d;
      done_q      <= done_d;
    end
  end

  // FIFO: storage is not reset, pointers and occupancy are.
  always_ff @(posedge ACLK) begin
    if (push) mem[wr_ptr_q] <= bus.rd_data;
  end

  always_ff @(posedge ACLK or posedge ARESETn) begin
    if (ARESETn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assert property (@(posedge ACLK) disable iff (ARESETn)
                   !(push && (count_q == CNT_W'(FIFO_DEPTH))));

  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign aborted       = aborted_q;
  assign bus.rd_req    = rd_req_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.rd_len    = rd_len_q;
  assign bus.rd_id     = RD_ID;
  assign bus.out_data  = mem[rd_ptr_q];
  assign bus.out_valid = !fifo_empty;

`ifdef DMA_RD_SCHED_PERF_EN
  logic        got_beat_q;
  logic        wait_c;
  logic [31:0] perf_busy_q, perf_wait_q;

  assign wait_c = ((state_q == ISSUE) && !abort && !space_ok) ||
                  ((state_q == DATA) && !got_beat_q && bus.rd_stall);

  always_ff @(posedge ACLK or posedge ARESETn) begin
    if (ARESETn) begin
      got_beat_q  <= 1'b0;
      perf_busy_q <= '0;
      perf_wait_q <= '0;
    end else begin
      if (rd_req_d)  got_beat_q <= 1'b0;
      else if (push) got_beat_q <= 1'b1;
      if (accept) begin
        perf_busy_q <= '0;
        perf_wait_q <= '0;
      end else begin
        if (busy && (perf_busy_q != '1))   perf_busy_q <= perf_busy_q + 32'd1;
        if (wait_c && (perf_wait_q != '1)) perf_wait_q <= perf_wait_q + 32'd1;
      end
    end
  end

  assign perf_busy_cycles = perf_busy_q;
  assign perf_wait_cycles = perf_wait_q;
`endif

endmodule

// File: tb/tb_dma_read_scheduler.sv
// Directed bench for dma_read_scheduler: burst splitting table, backpressure, abort, reset.
module tb_dma_read_scheduler;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        start;
  logic [31:0] src_addr;
  logic [15:0] len_words;
  logic        abort;
  logic        busy, done, aborted;

  dma_read_scheduler_if bus();

  dma_read_scheduler #(.RD_ID(4'hA)) dut (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .start     (start),
    .src_addr  (src_addr),
    .len_words (len_words),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .bus       (bus)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;

  logic [31:0] log_addr [8];
  logic [3:0]  log_len  [8];
  int          nb = 0;
  int          tot_beats = 0;
  int          stab_err = 0;
  int          rx_cnt = 0;
  logic        resp_kill = 1'b0;
  logic [31:0] exp_q [$];

  typedef struct {
    logic [31:0]      addr;
    int               len;
    int               nbursts;
    logic [2:0][31:0] ba;
    logic [2:0][3:0]  bl;
  } vec_t;

  vec_t vecs [6];

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Read-master model: one burst at a time, data derived from the beat address.
  initial begin
    bus.rd_rvalid = 1'b0;
    bus.rd_rlast  = 1'b0;
    bus.rd_data   = '0;
    bus.rd_stall  = 1'b0;
    forever begin
      @(negedge ACLK);
      if (bus.rd_req && !ARESETn) begin
        logic [31:0] a;
        logic [3:0]  l;
        a = bus.rd_addr;
        l = bus.rd_len;
        if (nb < 8) begin
          log_addr[nb] = a;
          log_len[nb]  = l;
        end
        nb++;
        bus.rd_stall = 1'b1;
        @(negedge ACLK);
        bus.rd_stall = 1'b0;
        @(negedge ACLK);
        for (int i = 0; i <= int'(l); i++) begin
          if (resp_kill) break;
          if (bus.rd_addr !== a || bus.rd_len !== l) stab_err++;
          bus.rd_rvalid = 1'b1;
          bus.rd_rlast  = (i == int'(l));
          bus.rd_data   = data_of(a + 32'(4 * i));
          tot_beats++;
          @(negedge ACLK);
        end
        bus.rd_rvalid = 1'b0;
        bus.rd_rlast  = 1'b0;
      end
    end
  end

  // Output stream checker: every popped word against the descriptor-derived sequence.
  initial begin
    forever begin
      @(negedge ACLK);
      #1;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL word_extra: got %0h expected no word", bus.out_data);
        end else begin
          chk("out_word", bus.out_data, exp_q.pop_front());
        end
        rx_cnt++;
      end
    end
  end

  task automatic kick(input logic [31:0] a, input int n);
    @(negedge ACLK);
    start     = 1'b1;
    src_addr  = a;
    len_words = 16'(n);
    for (int k = 0; k < n; k++) exp_q.push_back(data_of({a[31:2], 2'b00} + 32'(4 * k)));
    @(negedge ACLK);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int pulses);
    int n;
    pulses = 0;
    n = 0;
    while (n < budget) begin
      @(negedge ACLK);
      #1;
      if (done) pulses++;
      if (!busy && pulses > 0) break;
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected done within %0d cycles", budget);
    end
    repeat (3) begin
      @(negedge ACLK);
      #1;
      if (done) pulses++;
    end
  endtask

  task automatic wait_beats(input int target, input int budget);
    int n;
    n = 0;
    while (tot_beats < target && n < budget) begin
      @(negedge ACLK);
      #1;
      n++;
    end
    if (tot_beats < target) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: got %0d beats expected %0d", tot_beats, target);
    end
  endtask

  task automatic clear_test();
    exp_q.delete();
    rx_cnt   = 0;
    nb       = 0;
    stab_err = 0;
  endtask

  initial begin
    int pulses;
    ARESETn       = 1'b1;
    start         = 1'b0;
    src_addr      = '0;
    len_words     = '0;
    abort         = 1'b0;
    bus.out_ready = 1'b1;

    vecs[0] = '{32'h1000, 40, 3, {32'h1080, 32'h1040, 32'h1000}, {4'd7, 4'd15, 4'd15}};
    vecs[1] = '{32'h1FF0, 10, 2, {32'h0,    32'h2000, 32'h1FF0}, {4'd0, 4'd5,  4'd3}};
    vecs[2] = '{32'h0FFC,  3, 2, {32'h0,    32'h1000, 32'h0FFC}, {4'd0, 4'd1,  4'd0}};
    vecs[3] = '{32'h2003, 17, 2, {32'h0,    32'h2040, 32'h2000}, {4'd0, 4'd0,  4'd15}};
    vecs[4] = '{32'h3000,  5, 1, {32'h0,    32'h0,    32'h3000}, {4'd0, 4'd0,  4'd4}};
    vecs[5] = '{32'h0FC0, 20, 2, {32'h0,    32'h1000, 32'h0FC0}, {4'd0, 4'd3,  4'd15}};

    repeat (3) @(negedge ACLK);
    #1;
    chk("rst_busy",      32'(busy),          32'd0);
    chk("rst_done",      32'(done),          32'd0);
    chk("rst_aborted",   32'(aborted),       32'd0);
    chk("rst_rd_req",    32'(bus.rd_req),    32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_rd_addr",   bus.rd_addr,        32'd0);
    chk("rst_rd_len",    32'(bus.rd_len),    32'd0);
    chk("rst_rd_id",     32'(bus.rd_id),     32'hA);
    @(negedge ACLK);
    ARESETn = 1'b0;
    repeat (2) @(negedge ACLK);

    for (int i = 0; i < 6; i++) begin
      clear_test();
      kick(vecs[i].addr, vecs[i].len);
      wait_done(600, pulses);
      chk($sformatf("v%0d_nbursts", i), 32'(nb), 32'(vecs[i].nbursts));
      for (int j = 0; j < vecs[i].nbursts; j++) begin
        chk($sformatf("v%0d_b%0d_addr", i, j), log_addr[j], vecs[i].ba[j]);
        chk($sformatf("v%0d_b%0d_len", i, j), 32'(log_len[j]), 32'(vecs[i].bl[j]));
      end
      chk($sformatf("v%0d_words", i), 32'(rx_cnt), 32'(vecs[i].len));
      chk($sformatf("v%0d_done_pulses", i), 32'(pulses), 32'd1);
      chk($sformatf("v%0d_aborted", i), 32'(aborted), 32'd0);
      chk($sformatf("v%0d_addr_stable", i), 32'(stab_err), 32'd0);
    end

    // Zero-length descriptor: no burst, done two cycles after start.
    clear_test();
    @(negedge ACLK);
    start = 1'b1; src_addr = 32'h4000; len_words = '0;
    @(negedge ACLK);
    start = 1'b0;
    #1;
    chk("z_busy_c1", 32'(busy), 32'd1);
    chk("z_done_c1", 32'(done), 32'd0);
    @(negedge ACLK); #1;
    chk("z_done_c2", 32'(done), 32'd1);
    chk("z_busy_c2", 32'(busy), 32'd0);
    @(negedge ACLK); #1;
    chk("z_done_c3", 32'(done), 32'd0);
    chk("z_nbursts", 32'(nb),   32'd0);

    // Backpressure: two full bursts fill the FIFO, the third waits for 16 pops.
    clear_test();
    bus.out_ready = 1'b0;
    kick(32'h0, 48);
    repeat (80) @(negedge ACLK);
    #1;
    chk("bp_nbursts_full", 32'(nb), 32'd2);
    chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
    @(negedge ACLK);
    bus.out_ready = 1'b1;
    repeat (15) @(negedge ACLK);
    bus.out_ready = 1'b0;
    repeat (20) @(negedge ACLK);
    #1;
    chk("bp_nbursts_15pops", 32'(nb), 32'd2);
    chk("bp_words_15pops", 32'(rx_cnt), 32'd15);
    @(negedge ACLK);
    bus.out_ready = 1'b1;
    @(negedge ACLK);
    bus.out_ready = 1'b0;
    repeat (6) @(negedge ACLK);
    #1;
    chk("bp_nbursts_16pops", 32'(nb), 32'd3);
    chk("bp_b2_addr", log_addr[2], 32'h80);
    bus.out_ready = 1'b1;
    wait_done(600, pulses);
    chk("bp_words", 32'(rx_cnt), 32'd48);
    chk("bp_done_pulses", 32'(pulses), 32'd1);
    chk("bp_addr_stable", 32'(stab_err), 32'd0);

    // Abort during the second beat of the first burst.
    clear_test();
    kick(32'h0, 48);
    wait_beats(tot_beats + 2, 100);
    abort = 1'b1;
    wait_done(600, pulses);
    chk("ab_nbursts", 32'(nb), 32'd1);
    chk("ab_words", 32'(rx_cnt), 32'd16);
    chk("ab_aborted", 32'(aborted), 32'd1);
    chk("ab_done_pulses", 32'(pulses), 32'd1);
    abort = 1'b0;
    repeat (3) @(negedge ACLK);
    #1;
    chk("ab_aborted_sticky", 32'(aborted), 32'd1);

    // Start while busy is ignored; the accepted start clears aborted.
    clear_test();
    kick(32'h1000, 5);
    #1;
    chk("sb_aborted_clr", 32'(aborted), 32'd0);
    @(negedge ACLK);
    start = 1'b1; src_addr = 32'h5000; len_words = 16'd9;
    @(negedge ACLK);
    start = 1'b0;
    wait_done(600, pulses);
    chk("sb_nbursts", 32'(nb), 32'd1);
    chk("sb_b0_addr", log_addr[0], 32'h1000);
    chk("sb_b0_len", 32'(log_len[0]), 32'd4);
    chk("sb_words", 32'(rx_cnt), 32'd5);

    // Asynchronous reset in the middle of a burst, then a fresh descriptor.
    clear_test();
    kick(32'h0, 32);
    wait_beats(tot_beats + 3, 100);
    resp_kill = 1'b1;
    ARESETn   = 1'b1;
    #1;
    chk("rr_busy", 32'(busy), 32'd0);
    chk("rr_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rr_rd_req", 32'(bus.rd_req), 32'd0);
    @(negedge ACLK);
    ARESETn = 1'b0;
    repeat (2) @(negedge ACLK);
    resp_kill = 1'b0;
    clear_test();
    kick(32'h400, 4);
    wait_done(300, pulses);
    chk("rr_nbursts", 32'(nb), 32'd1);
    chk("rr_b0_addr", log_addr[0], 32'h400);
    chk("rr_b0_len", 32'(log_len[0]), 32'd3);
    chk("rr_words", 32'(rx_cnt), 32'd4);
    chk("rr_done_pulses", 32'(pulses), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
